// File: rtl/triangle_setup_pkg.sv
// Shared setup definitions: screen defaults,
// setup FSM states and the per-edge coefficient bundle.
package triangle_setup_pkg;

   localparam int LG_SCREEN_DEF = 11;
   localparam int SCREEN_W_DEF  = 640;
   localparam int SCREEN_H_DEF  = 480;

   typedef enum logic [2:0] {
      IDLE,
      BBOX,
      MUL,
      CHECK,
      ISSUE,
      WAIT
   } setup_state_t;

   typedef struct packed {
      logic [31:0] dx;
      logic [31:0] dy;
      logic [31:0] w00;
   } edge_coeff_t;

endpackage

// File: rtl/triangle_setup_mul.sv
// Registered signed W x W multiplier, 1-cycle latency.
// Ports: clk, rst, a/b signed operands, p 32-bit sign-extended product.
module triangle_setup_mul #(
   parameter int W = 13
) (
   input  logic                clk,
   input  logic                rst,
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [31:0]  p
);

   logic signed [31:0] p_q;
   logic signed [31:0] p_d;

   always_comb begin
      p_d = 32'(a) * 32'(b);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign p = p_q;

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: bbox, edge deltas/values, culling, generator issue.
// Ports: tri_val/tri_rdy vertex handshake, start/gen_done generator
// handshake, bbox + edge coefficient outputs, busy, issue/cull counters.
module triangle_setup
   import triangle_setup_pkg::*;
#(
   parameter int LG_SCREEN = LG_SCREEN_DEF,
   parameter int SCREEN_W  = SCREEN_W_DEF,
   parameter int SCREEN_H  = SCREEN_H_DEF,
   parameter int CULL_BACK = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tri_val,
   output logic                 tri_rdy,
   input  logic [LG_SCREEN-1:0] x0,
   input  logic [LG_SCREEN-1:0] y0,
   input  logic [LG_SCREEN-1:0] x1,
   input  logic [LG_SCREEN-1:0] y1,
   input  logic [LG_SCREEN-1:0] x2,
   input  logic [LG_SCREEN-1:0] y2,
   output logic                 start,
   output logic [31:0]          ymin,
   output logic [31:0]          ymax,
   output logic [31:0]          xmin,
   output logic [31:0]          xmax,
   output logic [31:0]          l0_dx,
   output logic [31:0]          l1_dx,
   output logic [31:0]          l2_dx,
   output logic [31:0]          l0_dy,
   output logic [31:0]          l1_dy,
   output logic [31:0]          l2_dy,
   output logic [31:0]          w0_00,
   output logic [31:0]          w1_00,
   output logic [31:0]          w2_00,
   input  logic                 gen_done,
   output logic                 busy,
   output logic [31:0]          tri_issued_cnt,
   output logic [31:0]          tri_culled_cnt
);

   localparam int DW = LG_SCREEN + 2;

   typedef logic [LG_SCREEN-1:0] crd_t;
   typedef logic signed [DW-1:0] dif_t;

   function automatic dif_t dif(input crd_t a, input crd_t b);
      return $signed({2'b00, a}) - $signed({2'b00, b});
   endfunction

   function automatic crd_t min3(input crd_t a, input crd_t b,
                                 input crd_t c);
      crd_t m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic crd_t max3(input crd_t a, input crd_t b,
                                 input crd_t c);
      crd_t m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   setup_state_t state_q, state_d;
   crd_t         vx_q [3];
   crd_t         vx_d [3];
   crd_t         vy_q [3];
   crd_t         vy_d [3];
   logic [31:0]  xmin_q, xmin_d, xmax_q, xmax_d;
   logic [31:0]  ymin_q, ymin_d, ymax_q, ymax_d;
   edge_coeff_t  edge_q [3];
   edge_coeff_t  edge_d [3];
   logic signed [31:0] acc_q, acc_d;
   logic [2:0]   cnt_q, cnt_d;
   logic         start_q, start_d;
   logic [31:0]  iss_q, iss_d, cul_q, cul_d;

   logic signed [31:0] prod;
   logic signed [31:0] area;
   dif_t         op_a, op_b;
   crd_t         xm, ym;
   crd_t         xlo, xhi, ylo, yhi;
   logic [31:0]  xend, yend, xmax_c, ymax_c;

   assign xlo = min3(vx_q[0], vx_q[1], vx_q[2]);
   assign xhi = max3(vx_q[0], vx_q[1], vx_q[2]);
   assign ylo = min3(vy_q[0], vy_q[1], vy_q[2]);
   assign yhi = max3(vy_q[0], vy_q[1], vy_q[2]);

   assign xend   = 32'(xhi) + 32'd1;
   assign yend   = 32'(yhi) + 32'd1;
   assign xmax_c = (xend > 32'(SCREEN_W)) ? 32'(SCREEN_W) : xend;
   assign ymax_c = (yend > 32'(SCREEN_H)) ? 32'(SCREEN_H) : yend;

   assign xm = xmin_q[LG_SCREEN-1:0];
   assign ym = ymin_q[LG_SCREEN-1:0];

   // Product order: even = (xmin-xa)*(yb-ya), odd = (ymin-ya)*(xb-xa)
   // for edges 0,1,2; then the two area terms.
   always_comb begin
      op_a = '0;
      op_b = '0;
      unique case (cnt_q)
         3'd0: begin op_a = dif(xm, vx_q[1]); op_b = dif(vy_q[2], vy_q[1]); end
         3'd1: begin op_a = dif(ym, vy_q[1]); op_b = dif(vx_q[2], vx_q[1]); end
         3'd2: begin op_a = dif(xm, vx_q[2]); op_b = dif(vy_q[0], vy_q[2]); end
         3'd3: begin op_a = dif(ym, vy_q[2]); op_b = dif(vx_q[0], vx_q[2]); end
         3'd4: begin op_a = dif(xm, vx_q[0]); op_b = dif(vy_q[1], vy_q[0]); end
         3'd5: begin op_a = dif(ym, vy_q[0]); op_b = dif(vx_q[1], vx_q[0]); end
         3'd6: begin op_a = dif(vx_q[0], vx_q[1]); op_b = dif(vy_q[2], vy_q[1]); end
         3'd7: begin op_a = dif(vy_q[0], vy_q[1]); op_b = dif(vx_q[2], vx_q[1]); end
         default: ;
      endcase
   end

   triangle_setup_mul #(.W(DW)) u_mul (
      .clk (clk),
      .rst (rst),
      .a   (op_a),
      .b   (op_b),
      .p   (prod)
   );

   always_comb begin
      state_d = state_q;
      vx_d    = vx_q;
      vy_d    = vy_q;
      xmin_d  = xmin_q;
      xmax_d  = xmax_q;
      ymin_d  = ymin_q;
      ymax_d  = ymax_q;
      edge_d  = edge_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      start_d = 1'b0;
      iss_d   = iss_q;
      cul_d   = cul_q;
      // Last area term lands from the multiplier during CHECK.
      area    = acc_q - prod;
      unique case (state_q)
         IDLE: begin
            if (tri_val) begin
               vx_d[0] = x0;
               vx_d[1] = x1;
               vx_d[2] = x2;
               vy_d[0] = y0;
               vy_d[1] = y1;
               vy_d[2] = y2;
               state_d = BBOX;
            end
         end
         BBOX: begin
            xmin_d = 32'(xlo);
            xmax_d = xmax_c;
            ymin_d = 32'(ylo);
            ymax_d = ymax_c;
            for (int i = 0; i < 3; i++) begin
               edge_d[i].dx = 32'(dif(vy_q[(i+2)%3], vy_q[(i+1)%3]));
               edge_d[i].dy = 32'(dif(vx_q[(i+1)%3], vx_q[(i+2)%3]));
            end
            cnt_d   = 3'd0;
            state_d = MUL;
         end
         MUL: begin
            cnt_d = cnt_q + 3'd1;
            // Product cnt_q-1 is on the multiplier output now.
            if (cnt_q[0]) begin
               acc_d = prod;
            end else begin
               case (cnt_q)
                  3'd2: edge_d[0].w00 = acc_q - prod;
                  3'd4: edge_d[1].w00 = acc_q - prod;
                  3'd6: edge_d[2].w00 = acc_q - prod;
                  default: ;
               endcase
            end
            if (cnt_q == 3'd7) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (xmin_q >= xmax_q || ymin_q >= ymax_q) begin
               cul_d   = cul_q + 32'd1;
               state_d = IDLE;
            end else if (area == 0 || (CULL_BACK != 0 && area < 0)) begin
               cul_d   = cul_q + 32'd1;
               state_d = IDLE;
            end else begin
               iss_d   = iss_q + 32'd1;
               start_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (gen_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vx_q    <= '{default: '0};
         vy_q    <= '{default: '0};
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymin_q  <= '0;
         ymax_q  <= '0;
         edge_q  <= '{default: '0};
         acc_q   <= '0;
         cnt_q   <= '0;
         start_q <= 1'b0;
         iss_q   <= '0;
         cul_q   <= '0;
      end else begin
         state_q <= state_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymin_q  <= ymin_d;
         ymax_q  <= ymax_d;
         edge_q  <= edge_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         iss_q   <= iss_d;
         cul_q   <= cul_d;
      end
   end

   assign tri_rdy        = (state_q == IDLE);
   assign busy           = (state_q != IDLE);
   assign start          = start_q;
   assign xmin           = xmin_q;
   assign xmax           = xmax_q;
   assign ymin           = ymin_q;
   assign ymax           = ymax_q;
   assign l0_dx          = edge_q[0].dx;
   assign l1_dx          = edge_q[1].dx;
   assign l2_dx          = edge_q[2].dx;
   assign l0_dy          = edge_q[0].dy;
   assign l1_dy          = edge_q[1].dy;
   assign l2_dy          = edge_q[2].dy;
   assign w0_00          = edge_q[0].w00;
   assign w1_00          = edge_q[1].w00;
   assign w2_00          = edge_q[2].w00;
   assign tri_issued_cnt = iss_q;
   assign tri_culled_cnt = cul_q;

endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup; instance 0 culls back faces,
// instance 1 keeps them. Both share the same stimulus.
module tb_triangle_setup;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tri_val = 1'b0;
   logic        gen_done = 1'b0;
   logic [10:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;

   logic        rdy [2];
   logic        st  [2];
   logic        bsy [2];
   logic [31:0] ymn [2], ymx [2], xmn [2], xmx [2];
   logic [31:0] d0x [2], d1x [2], d2x [2];
   logic [31:0] d0y [2], d1y [2], d2y [2];
   logic [31:0] w0  [2], w1  [2], w2  [2];
   logic [31:0] icnt [2], ccnt [2];

   int checks = 0;
   int failures = 0;
   int iss [2] = '{0, 0};
   int cul [2] = '{0, 0};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      triangle_setup #(.CULL_BACK(g == 0 ? 1 : 0)) u_dut (
         .clk            (clk),
         .rst            (rst),
         .tri_val        (tri_val),
         .tri_rdy        (rdy[g]),
         .x0             (x0),
         .y0             (y0),
         .x1             (x1),
         .y1             (y1),
         .x2             (x2),
         .y2             (y2),
         .start          (st[g]),
         .ymin           (ymn[g]),
         .ymax           (ymx[g]),
         .xmin           (xmn[g]),
         .xmax           (xmx[g]),
         .l0_dx          (d0x[g]),
         .l1_dx          (d1x[g]),
         .l2_dx          (d2x[g]),
         .l0_dy          (d0y[g]),
         .l1_dy          (d1y[g]),
         .l2_dy          (d2y[g]),
         .w0_00          (w0[g]),
         .w1_00          (w1[g]),
         .w2_00          (w2[g]),
         .gen_done       (gen_done),
         .busy           (bsy[g]),
         .tri_issued_cnt (icnt[g]),
         .tri_culled_cnt (ccnt[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, $signed(got),
                  $signed(exp));
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic setv(input logic [10:0] a0, input logic [10:0] b0,
                       input logic [10:0] a1, input logic [10:0] b1,
                       input logic [10:0] a2, input logic [10:0] b2);
      x0 = a0; y0 = b0; x1 = a1; y1 = b1; x2 = a2; y2 = b2;
   endtask

   // Presents a triangle, waits for both instances to accept it, and
   // returns in cycle T+11. Inputs are scrambled after the accept edge.
   task automatic accept(input logic [10:0] a0, input logic [10:0] b0,
                         input logic [10:0] a1, input logic [10:0] b1,
                         input logic [10:0] a2, input logic [10:0] b2,
                         input bit spur);
      int  n;
      logic early;
      setv(a0, b0, a1, b1, a2, b2);
      tri_val = 1'b1;
      n = 0;
      while (!(rdy[0] && rdy[1]) && n < 50) begin
         tick;
         n++;
      end
      chk("rdy_timeout", 32'(n < 50), 1);
      tick;
      tri_val = 1'b0;
      setv(11'd5, 11'd9, 11'd300, 11'd7, 11'd2, 11'd400);
      early = st[0] | st[1];
      for (int c = 2; c <= 10; c++) begin
         tick;
         gen_done = spur && (c == 4);
         early |= st[0] | st[1];
      end
      tick;
      gen_done = 1'b0;
      chk("early_start", 32'(early), 0);
   endtask

   task automatic done_pulse;
      gen_done = 1'b1;
      tick;
      gen_done = 1'b0;
   endtask

   initial begin
      logic any;
      repeat (3) tick;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("rst_start%0d", g), 32'(st[g]), 0);
         chk($sformatf("rst_busy%0d", g), 32'(bsy[g]), 0);
         chk($sformatf("rst_xmax%0d", g), xmx[g], 0);
         chk($sformatf("rst_w0%0d", g), w0[g], 0);
         chk($sformatf("rst_icnt%0d", g), icnt[g], 0);
         chk($sformatf("rst_ccnt%0d", g), ccnt[g], 0);
      end
      rst = 1'b0;
      tick;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("idle_rdy%0d", g), 32'(rdy[g]), 1);
      end

      // Front-facing, with a spurious gen_done during MUL.
      accept(0, 0, 0, 4, 4, 0, 1'b1);
      for (int g = 0; g < 2; g++) begin
         iss[g]++;
         chk($sformatf("f_start%0d", g), 32'(st[g]), 1);
         chk($sformatf("f_ymin%0d", g), ymn[g], 0);
         chk($sformatf("f_ymax%0d", g), ymx[g], 5);
         chk($sformatf("f_xmin%0d", g), xmn[g], 0);
         chk($sformatf("f_xmax%0d", g), xmx[g], 5);
         chk($sformatf("f_l0dx%0d", g), d0x[g], -4);
         chk($sformatf("f_l0dy%0d", g), d0y[g], -4);
         chk($sformatf("f_l1dx%0d", g), d1x[g], 0);
         chk($sformatf("f_l1dy%0d", g), d1y[g], 4);
         chk($sformatf("f_l2dx%0d", g), d2x[g], 4);
         chk($sformatf("f_l2dy%0d", g), d2y[g], 0);
         chk($sformatf("f_w0%0d", g), w0[g], 16);
         chk($sformatf("f_w1%0d", g), w1[g], 0);
         chk($sformatf("f_w2%0d", g), w2[g], 0);
         chk($sformatf("f_icnt%0d", g), icnt[g], iss[g]);
         chk($sformatf("f_rdy%0d", g), 32'(rdy[g]), 0);
      end

      // Backpressure: next triangle held on the inputs during WAIT.
      setv(0, 0, 2, 2, 4, 4);
      tri_val = 1'b1;
      tick;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("w_start%0d", g), 32'(st[g]), 0);
         chk($sformatf("w_rdy%0d", g), 32'(rdy[g]), 0);
         chk($sformatf("w_w0%0d", g), w0[g], 16);
      end
      tick;
      tick;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("w3_rdy%0d", g), 32'(rdy[g]), 0);
         chk($sformatf("w3_xmax%0d", g), xmx[g], 5);
         chk($sformatf("w3_icnt%0d", g), icnt[g], iss[g]);
      end
      done_pulse;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("d_rdy%0d", g), 32'(rdy[g]), 1);
      end

      // Degenerate triangle, accepted straight out of WAIT.
      accept(0, 0, 2, 2, 4, 4, 1'b0);
      for (int g = 0; g < 2; g++) begin
         cul[g]++;
         chk($sformatf("g_start%0d", g), 32'(st[g]), 0);
         chk($sformatf("g_ccnt%0d", g), ccnt[g], cul[g]);
         chk($sformatf("g_rdy%0d", g), 32'(rdy[g]), 1);
      end

      // Back-facing: culled by instance 0, issued by instance 1.
      accept(0, 0, 4, 0, 0, 4, 1'b0);
      cul[0]++;
      iss[1]++;
      chk("b_start0", 32'(st[0]), 0);
      chk("b_rdy0", 32'(rdy[0]), 1);
      chk("b_ccnt0", ccnt[0], cul[0]);
      chk("b_start1", 32'(st[1]), 1);
      chk("b_w0_1", w0[1], -16);
      chk("b_l0dx1", d0x[1], 4);
      chk("b_l0dy1", d0y[1], 4);
      chk("b_l1dx1", d1x[1], -4);
      chk("b_l2dy1", d2y[1], -4);
      chk("b_icnt1", icnt[1], iss[1]);
      // gen_done coincident with start must not complete it.
      done_pulse;
      chk("b_cdone_rdy1", 32'(rdy[1]), 0);
      chk("b_cdone_busy1", 32'(bsy[1]), 1);
      done_pulse;
      chk("b_done_rdy1", 32'(rdy[1]), 1);

      // Fully off-screen in x.
      accept(700, 10, 700, 20, 710, 10, 1'b0);
      for (int g = 0; g < 2; g++) begin
         cul[g]++;
         chk($sformatf("o_start%0d", g), 32'(st[g]), 0);
         chk($sformatf("o_xmin%0d", g), xmn[g], 700);
         chk($sformatf("o_xmax%0d", g), xmx[g], 640);
         chk($sformatf("o_ymax%0d", g), ymx[g], 21);
         chk($sformatf("o_ccnt%0d", g), ccnt[g], cul[g]);
      end

      // Partially off-screen, clamped.
      accept(630, 0, 630, 10, 650, 0, 1'b0);
      for (int g = 0; g < 2; g++) begin
         iss[g]++;
         chk($sformatf("p_start%0d", g), 32'(st[g]), 1);
         chk($sformatf("p_xmin%0d", g), xmn[g], 630);
         chk($sformatf("p_xmax%0d", g), xmx[g], 640);
         chk($sformatf("p_ymax%0d", g), ymx[g], 11);
         chk($sformatf("p_l0dx%0d", g), d0x[g], -10);
         chk($sformatf("p_l0dy%0d", g), d0y[g], -20);
         chk($sformatf("p_w0%0d", g), w0[g], 200);
         chk($sformatf("p_icnt%0d", g), icnt[g], iss[g]);
      end
      tick;
      done_pulse;

      // Reset during MUL aborts the triangle.
      setv(0, 0, 0, 4, 4, 0);
      tri_val = 1'b1;
      tick;
      tri_val = 1'b0;
      repeat (4) tick;
      rst = 1'b1;
      tick;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("r_start%0d", g), 32'(st[g]), 0);
         chk($sformatf("r_busy%0d", g), 32'(bsy[g]), 0);
         chk($sformatf("r_rdy%0d", g), 32'(rdy[g]), 1);
         chk($sformatf("r_xmax%0d", g), xmx[g], 0);
         chk($sformatf("r_w0%0d", g), w0[g], 0);
         chk($sformatf("r_icnt%0d", g), icnt[g], 0);
         chk($sformatf("r_ccnt%0d", g), ccnt[g], 0);
      end
      rst = 1'b0;
      any = 1'b0;
      repeat (12) begin
         tick;
         any |= st[0] | st[1];
      end
      chk("r_no_start", 32'(any), 0);
      chk("r_icnt_after", icnt[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/triangle_setup.md
Name: triangle_setup

Overview:
- Upstream neighbour of the fragment generator.
- Accepts one screen-space triangle (three integer pixel vertices) over a valid/ready handshake.
- Computes the clamped exclusive bounding box, per-edge step deltas and edge-function values at (xmin,ymin).
- Culls back-facing, degenerate and off-screen triangles, issues a one-cycle start to the generator, and holds its coefficients stable until the generator signals done.

Parameters:
- LG_SCREEN, 11, log2 of max screen dimension; vertex coordinates are unsigned LG_SCREEN bits.
- SCREEN_W, 640, framebuffer width; x clamp bound (exclusive).
- SCREEN_H, 480, framebuffer height; y clamp bound (exclusive).
- CULL_BACK, 1, 1 = drop triangles with area<=0; 0 = drop only area==0.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- tri_val  in  1  triangle valid
- tri_rdy  out  1  setup can accept a triangle
- x0,y0,x1,y1,x2,y2  in  LG_SCREEN each  vertex coordinates, unsigned
- start  out  1  one-cycle pulse to the generator
- ymin,ymax,xmin,xmax  out  32  bbox; max bounds exclusive
- l0_dx,l1_dx,l2_dx  out  32  signed per-x-step edge increment
- l0_dy,l1_dy,l2_dy  out  32  signed per-y-step edge increment
- w0_00,w1_00,w2_00  out  32  signed edge values at (xmin,ymin)
- gen_done  in  1  generator finished the current triangle
- busy  out  1  state != IDLE
- tri_issued_cnt  out  32  triangles sent to the generator
- tri_culled_cnt  out  32  triangles dropped

Behaviour:
- Reset and clock: rst synchronous, active-high; clock clk.
- Reset values: all outputs 0, state IDLE, tri_rdy=1 after reset releases.
- Reset mid-operation aborts immediately; the generator shares rst.

Edge and area definitions:
- Edge from va to vb: E(x,y) = (x-xa)*(yb-ya) - (y-ya)*(xb-xa).
- Edge 0 is v1->v2, edge 1 is v2->v0, edge 2 is v0->v1.
- li_dx = yb-ya.
- li_dy = -(xb-xa).
- wi_00 = E_i(xmin,ymin).
- area = (x0-x1)*(y2-y1) - (y0-y1)*(x2-x1).
- Differences are sign-extended to LG_SCREEN+2 bits. Products and sums are sign-extended to 32 bits, so no overflow is possible.

Bounding box:
- xmin = min(x0,x1,x2).
- xmax = min(max(x0,x1,x2)+1, SCREEN_W).
- ymin and ymax are computed the same way, using SCREEN_H.

State machine (tri_rdy = state==IDLE):
- IDLE: tri_val&tri_rdy at cycle T latches the vertices; next state BBOX.
- BBOX (T+1): register the bbox and the six deltas.
- MUL (T+2..T+9): one registered signed multiply per cycle, 8 products in fixed order: w0 terms, w1 terms, w2 terms, then area terms. Each difference pair is accumulated on completion.
- CHECK (T+10), in priority order:
  - if xmin>=xmax or ymin>=ymax, cull;
  - else if area==0, or (CULL_BACK and area<0), cull;
  - else go to ISSUE.
  - A cull increments tri_culled_cnt and returns to IDLE; tri_rdy is high at T+11.
- ISSUE (T+11): start=1 for exactly one cycle; tri_issued_cnt++. All coefficient outputs are valid from this cycle.
- WAIT: outputs held constant. gen_done=1 returns to IDLE, and tri_rdy is 1 the following cycle.
- gen_done in any other state is ignored.
- gen_done coincident with start cannot complete the triangle; it is ignored.
- Counters wrap at 2^32.
- Inputs x*/y* are only sampled on the accept cycle; later changes have no effect.

Decomposition:
- Shared package (rasterizer.vh):
  - LG_SCREEN, SCREEN_W, SCREEN_H defaults;
  - setup state enum: IDLE, BBOX, MUL, CHECK, ISSUE, WAIT;
  - edge_coeff_t struct {dx,dy,w00}.
- One sub-module, setup_mul: a registered signed (LG_SCREEN+2)x(LG_SCREEN+2) multiplier with 1-cycle latency, sign-extended to 32 bits.
- The multiply sequencing counter (3 bits) stays in triangle_setup.

Test Plan:
- Front-facing triangle: v=(0,0),(0,4),(4,0) accepted at T.
  - start at T+11.
  - bbox 0,5,0,5.
  - l0 dx/dy = -4/-4, l1 = 0/4, l2 = 4/0.
  - w00 = 16/0/0.
  - issued_cnt=1.
- Back-facing triangle with CULL_BACK=1: v=(0,0),(4,0),(0,4), area -16.
  - No start; culled_cnt=1; tri_rdy high at T+11.
  - Repeat with CULL_BACK=0: start issued.
- Degenerate collinear triangle (0,0),(2,2),(4,4): culled in both CULL_BACK settings.
- Off-screen clamp: v=(700,10),(700,20),(710,10) with SCREEN_W=640.
  - xmin=700 >= xmax=640, so culled.
  - A partially-off triangle (630,0),(630,10),(650,0) gives xmax=640.
- Handshake and backpressure:
  - Hold tri_val during WAIT: tri_rdy=0 and outputs stable.
  - gen_done 3 cycles after start: tri_rdy=1 next cycle, second triangle accepted.
  - A spurious gen_done in MUL is ignored.
- Reset mid-MUL: assert rst at T+5.
  - Next cycle all outputs 0, counters 0, tri_rdy=1.
  - No start ever emitted for the aborted triangle.
